// File: rtl/simon_round_ctrl.sv
// simon_round_ctrl: Simon 64/128 key-expansion and round sequencer; define SIMON_KEY_CACHE_EN to skip re-expanding a repeated key
module simon_round_ctrl #(
  parameter int ROUNDS = 44,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_block,
  input  logic [127:0]      in_key,
  output logic              ks_load,
  output logic [127:0]      ks_key,
  input  logic              ks_valid,
  input  logic [31:0]       ks_word,
  output logic              kram_we,
  output logic [ADDR_W-1:0] kram_waddr,
  output logic [31:0]       kram_wdata,
  output logic              kram_re,
  output logic [ADDR_W-1:0] kram_raddr,
  output logic              rnd_valid,
  output logic [31:0]       rnd_x,
  output logic [31:0]       rnd_y,
  input  logic              rnd_done,
  input  logic [31:0]       rnd_x_new,
  input  logic [31:0]       rnd_y_new,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_block,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, LOAD, EXPAND, FETCH, ROUND, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROUNDS - 1);
  state_t state, state_nx;
  logic [31:0] x, y;
  logic [127:0] key;
  logic [ADDR_W-1:0] wcnt, rcnt;
  logic take, hit, wr_last;
  assign take = in_valid && state == IDLE;
  assign wr_last = kram_we && wcnt == LAST;
`ifdef SIMON_KEY_CACHE_EN
  logic [127:0] cache_key;
  logic cache_ok;
  assign hit = cache_ok && in_key == cache_key;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_ok <= 1'b0;
      cache_key <= '0;
    end else if (state == LOAD) begin
      cache_ok <= 1'b0;
    end else if (wr_last) begin
      cache_ok <= 1'b1;
      cache_key <= key;
    end
  end
`else
  assign hit = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = take ? (hit ? FETCH : LOAD) : IDLE;
      LOAD:    state_nx = EXPAND;
      EXPAND:  state_nx = wr_last ? FETCH : EXPAND;
      FETCH:   state_nx = ROUND;
      ROUND:   state_nx = rnd_done ? (rcnt == LAST ? DONE : FETCH) : ROUND;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      key <= '0;
      wcnt <= '0;
      rcnt <= '0;
      rnd_valid <= 1'b0;
    end else begin
      state <= state_nx;
      rnd_valid <= state == FETCH;
      if (take) begin
        {x, y} <= in_block;
        key <= in_key;
        rcnt <= '0;
      end
      if (state == LOAD) wcnt <= '0;
      if (kram_we) wcnt <= wcnt + 1'b1;
      if (state == ROUND && rnd_done) begin
        x <= rnd_x_new;
        y <= rnd_y_new;
        if (rcnt != LAST) rcnt <= rcnt + 1'b1;
      end
    end
  end
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign ks_load = state == LOAD;
  assign ks_key = key;
  assign kram_we = state == EXPAND && ks_valid;
  assign kram_waddr = wcnt;
  assign kram_wdata = kram_we ? ks_word : '0;
  assign kram_re = state == FETCH;
  assign kram_raddr = rcnt;
  assign rnd_x = x;
  assign rnd_y = y;
  assign out_valid = state == DONE;
  assign out_block = {x, y};
endmodule

// File: doc/simon_round_ctrl.md
Name: simon_round_ctrl

Overview:
- Sequencer for the Simon 64/128 encryption datapath.
- Accepts one plaintext block and key per valid/ready handshake, then runs two phases:
  - Key expansion: drives an external streaming key-schedule unit and writes its ROUNDS round keys into the round-key RAM.
  - Encryption: iterates the external round unit ROUNDS times, reading one round key per round.
- Holds the cipher state (x, y) internally and presents the ciphertext on an output handshake.

Parameters:
- ROUNDS, 44, number of rounds and round keys.
- ADDR_W, 6, round-key RAM address width; 2^ADDR_W must be at least ROUNDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_block  in  64  plaintext; [63:32] is x, [31:0] is y.
- in_key  in  128  master key.
- ks_load  out  1  one-cycle pulse that starts the key-schedule unit.
- ks_key  out  128  registered key, stable from ks_load until return to IDLE.
- ks_valid  in  1  key-schedule word valid.
- ks_word  in  32  round key; words arrive in order 0..ROUNDS-1.
- kram_we  out  1  RAM write enable.
- kram_waddr  out  ADDR_W  RAM write address.
- kram_wdata  out  32  RAM write data (equals ks_word).
- kram_re  out  1  RAM read enable; RAM read latency is 1 cycle.
- kram_raddr  out  ADDR_W  RAM read address.
- rnd_valid  out  1  one-cycle pulse; RAM read data feeds the round unit's key input directly.
- rnd_x, rnd_y  out  32 each  current state to the round unit.
- rnd_done  in  1  round result valid (latency of 1 or more cycles).
- rnd_x_new, rnd_y_new  in  32 each  round result.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  ciphertext accepted.
- out_block  out  64  ciphertext {x, y}.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
Reset:
- Asynchronous, any time including mid-operation.
- State goes to IDLE.
- All outputs 0 except in_ready=1.
- Internal x, y, key, wcnt and rcnt cleared.

States and transitions:
- IDLE:
  - On in_valid && in_ready, latch x, y and key; go to LOAD.
  - in_valid without the handshake has no effect.
- LOAD:
  - ks_load=1 for exactly one cycle; wcnt=0; go to EXPAND.
- EXPAND:
  - On each ks_valid cycle: kram_we=1, kram_waddr=wcnt, kram_wdata=ks_word, then wcnt increments.
  - When word ROUNDS-1 is written, go to FETCH with rcnt=0 in the next cycle.
  - ks_valid gaps are allowed.
  - ks_valid outside EXPAND is ignored; no RAM write occurs.
- FETCH:
  - kram_re=1 and kram_raddr=rcnt for one cycle; go to ROUND.
- ROUND:
  - In the entry cycle, rnd_valid=1 with rnd_x/rnd_y equal to the stored x/y; RAM data for key rcnt is valid in this same cycle.
  - Wait for rnd_done. rnd_done in the entry cycle itself is legal.
  - On rnd_done, latch x=rnd_x_new and y=rnd_y_new.
  - If rcnt==ROUNDS-1, go to DONE; otherwise rcnt increments and state goes to FETCH.
  - rnd_done outside ROUND is ignored.
- DONE:
  - out_valid=1 and out_block={x, y}, both held stable until out_ready.
  - On out_valid && out_ready, go to IDLE. in_ready rises the following cycle, never the same cycle.

Timing:
- Per-round cost is 2 cycles plus the round-unit latency beyond 1 cycle.
- Total latency with the key schedule delivering 1 word/cycle and round latency 1:
  - 1 (LOAD) + ROUNDS (EXPAND) + 2·ROUNDS (FETCH/ROUND) + 1 (DONE entry).
  - With ROUNDS=44 this is 134 cycles from handshake to out_valid.

General rules:
- Counters are ADDR_W bits and never wrap within an operation.
- Output handshake signals are registered; none are combinational from inputs.

Optional Feature:
- Macro: SIMON_KEY_CACHE_EN.
- Defined:
  - Add a 128-bit cached key register and a cache_ok flag.
  - cache_ok sets on completion of EXPAND.
  - cache_ok clears on rst or when an expansion starts.
  - At handshake, if cache_ok && in_key==cached key, IDLE goes directly to FETCH. ks_load and RAM writes are skipped; latency is reduced by 1+ROUNDS.
- Undefined:
  - Every request passes through LOAD/EXPAND.
  - No cache storage exists.

Test Plan:
1. Known-answer test, behavioural key-schedule unit and round unit (1-cycle latency):
   - Stimulus: key 0x1b1a1918_13121110_0b0a0908_03020100, plaintext 0x656b696c_20646e75.
   - Response: out_block 0x44c8fc20_b9dfa07a; out_valid exactly 134 cycles after the handshake; 44 RAM writes to addresses 0..43.
2. Backpressure and stalls:
   - Stimulus: out_ready held low 10 cycles; ks_valid and rnd_done randomly stalled.
   - Response: out_block stable while stalled; in_ready=0 throughout; same ciphertext as test 1.
3. Reset mid-operation:
   - Stimulus: rst asserted in ROUND at rcnt=20, then a new request with the test-1 vector.
   - Response: in_ready=1 immediately after reset; correct ciphertext for the new request; with SIMON_KEY_CACHE_EN defined, a full expansion occurs.
4. Spurious inputs:
   - Stimulus: ks_valid in IDLE/ROUND, rnd_done in FETCH/EXPAND, in_valid while busy.
   - Response: no kram_we, no state change, no accepted request.
5. Back-to-back requests, same key:
   - With SIMON_KEY_CACHE_EN defined: second request shows no ks_load; out_valid at 89 cycles.
   - Without the macro: out_valid at 134 cycles.
   - Both ciphertexts correct.
